riscv_core_icache_controller: RTL

Hit/miss and refill controller for the direct-mapped instruction cache: 128 sets of 32-byte blocks, 64-bit address, tag = addr[63:12], index = addr[11:5].
- Holds the tag and valid arrays.
- Checks both blocks a 32-bit fetch may span: the block of addr and the block of addr+2.
- Stalls the core on a miss and sequences one block read per missing block from the AXI read module.
- Drives the data memory's rd_en, wr_en, block_replace and offset controls.

---
 rtl/riscv_core_icache_pkg.sv | 30 +++
 rtl/riscv_core_icache_tag_array.sv | 46 ++++
 rtl/riscv_core_icache_controller.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/riscv_core_icache_pkg.sv
// Shared definitions for the instruction cache controller: address field
// ranges, cache geometry, FSM state type and a block-alignment helper.
package riscv_core_icache_pkg;

    localparam int ADDR_WIDTH       = 64;
    localparam int INDEX_WIDTH      = 7;
    localparam int TAG_WIDTH        = 52;
    localparam int CACHE_DEPTH      = 128;

    localparam int TAG_MSB          = 63;
    localparam int TAG_LSB          = 12;
    localparam int INDEX_MSB        = 11;
    localparam int INDEX_LSB        = 5;
    localparam int BLOCK_OFFSET_MSB = 4;
    localparam int BLOCK_OFFSET_LSB = 2;
    localparam int BYTE_OFFSET_MSB  = 1;
    localparam int BYTE_OFFSET_LSB  = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MISS0 = 2'd1,
        MISS1 = 2'd2
    } icache_state_e;

    // Clear the in-block offset so the address points at the block start.
    function automatic logic [ADDR_WIDTH-1:0] block_addr(input logic [ADDR_WIDTH-1:0] addr);
        return {addr[ADDR_WIDTH-1:INDEX_LSB], 5'b00000};
    endfunction

endpackage

// File: rtl/riscv_core_icache_tag_array.sv
// Tag and valid storage for the direct-mapped instruction cache.
// Two combinational lookup ports (block of addr, block of addr+2) and one
// refill write port. Flush clears every valid bit and beats a same-cycle
// valid set; tags are never cleared.
module riscv_core_icache_tag_array
    import riscv_core_icache_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   wr_en,
    input  logic [INDEX_WIDTH-1:0] wr_idx,
    input  logic [TAG_WIDTH-1:0]   wr_tag,
    input  logic [INDEX_WIDTH-1:0] idx0,
    input  logic [TAG_WIDTH-1:0]   tag0,
    input  logic [INDEX_WIDTH-1:0] idx1,
    input  logic [TAG_WIDTH-1:0]   tag1,
    output logic                   hit0,
    output logic                   hit1
);

    logic [TAG_WIDTH-1:0]   tag_mem_r [CACHE_DEPTH];
    logic [CACHE_DEPTH-1:0] valid_r;

    // Tag storage: written on every refill, even one whose valid is dropped.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem_r[wr_idx] <= wr_tag;
        end
    end

    // Valid bits: reset and flush clear all; a refill sets its set's bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_r <= {CACHE_DEPTH{1'b0}};
        end else if (flush) begin
            valid_r <= {CACHE_DEPTH{1'b0}};
        end else if (wr_en) begin
            valid_r[wr_idx] <= 1'b1;
        end
    end

    assign hit0 = valid_r[idx0] && (tag_mem_r[idx0] == tag0);
    assign hit1 = valid_r[idx1] && (tag_mem_r[idx1] == tag1);

endmodule

// File: rtl/riscv_core_icache_controller.sv
// Hit/miss and refill controller for the direct-mapped instruction cache.
// A 32-bit fetch may straddle two blocks, so both the block of addr and of
// addr+2 are looked up; each missing block is refilled with one AXI block
// read, then the fetch is re-evaluated and served from IDLE.
module riscv_core_icache_controller
    import riscv_core_icache_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [ADDR_WIDTH-1:0] i_addr_from_core,
    input  logic                  i_req,
    input  logic                  i_flush,
    output logic                  o_stall,
    output logic                  o_rd_en,
    output logic                  o_wr_en,
    output logic                  o_block_replace,
    output logic                  o_offset,
    output logic                  o_axi_req,
    output logic [ADDR_WIDTH-1:0] o_axi_addr,
    input  logic                  i_axi_done,
    input  logic                  i_axi_err,
    output logic                  o_bus_error
);

    icache_state_e          state_r;
    icache_state_e          next_state_s;
    logic [ADDR_WIDTH-1:0]  a2_s;
    logic [ADDR_WIDTH-1:0]  blk0_s;
    logic [ADDR_WIDTH-1:0]  blk1_s;
    logic                   same_block_s;
    logic                   hit0_s;
    logic                   hit1_s;
    logic                   done_ok_s;
    logic                   done_err_s;
    logic [INDEX_WIDTH-1:0] wr_idx_s;
    logic [TAG_WIDTH-1:0]   wr_tag_s;

    assign a2_s         = i_addr_from_core + 64'd2;
    assign blk0_s       = block_addr(i_addr_from_core);
    assign blk1_s       = block_addr(a2_s);
    assign same_block_s = (blk0_s == blk1_s);
    assign done_ok_s    = i_axi_done && !i_axi_err;
    assign done_err_s   = i_axi_done && i_axi_err;

    // The refill target follows the offset: MISS0 writes a0's set, MISS1 a2's.
    assign wr_idx_s = o_offset ? blk1_s[INDEX_MSB:INDEX_LSB] : blk0_s[INDEX_MSB:INDEX_LSB];
    assign wr_tag_s = o_offset ? blk1_s[TAG_MSB:TAG_LSB]     : blk0_s[TAG_MSB:TAG_LSB];

    riscv_core_icache_tag_array u_tag_array (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .flush  (i_flush),
        .wr_en  (o_wr_en),
        .wr_idx (wr_idx_s),
        .wr_tag (wr_tag_s),
        .idx0   (blk0_s[INDEX_MSB:INDEX_LSB]),
        .tag0   (blk0_s[TAG_MSB:TAG_LSB]),
        .idx1   (blk1_s[INDEX_MSB:INDEX_LSB]),
        .tag1   (blk1_s[TAG_MSB:TAG_LSB]),
        .hit0   (hit0_s),
        .hit1   (hit1_s)
    );

    // State register with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic: miss the a0 block first, then the a2 block if needed.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (i_req && !hit0_s) begin
                    next_state_s = MISS0;
                end else if (i_req && !hit1_s) begin
                    next_state_s = MISS1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            MISS0: begin
                if (done_ok_s) begin
                    next_state_s = (!same_block_s && !hit1_s) ? MISS1 : IDLE;
                end else if (done_err_s) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = MISS0;
                end
            end
            MISS1: begin
                if (i_axi_done) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = MISS1;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Output decode: zero-latency hit in IDLE, refill handshake in MISS states;
    // everything is held low while reset is asserted.
    always_comb begin
        o_stall         = 1'b0;
        o_rd_en         = 1'b0;
        o_wr_en         = 1'b0;
        o_block_replace = 1'b0;
        o_offset        = 1'b0;
        o_axi_req       = 1'b0;
        o_axi_addr      = {ADDR_WIDTH{1'b0}};
        o_bus_error     = 1'b0;
        if (!i_rst_n) begin
            o_stall = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    o_rd_en = i_req && hit0_s && hit1_s;
                    o_stall = i_req && !(hit0_s && hit1_s);
                end
                MISS0, MISS1: begin
                    o_stall    = 1'b1;
                    o_axi_req  = 1'b1;
                    o_offset   = (state_r == MISS1);
                    o_axi_addr = (state_r == MISS1) ? blk1_s : blk0_s;
                    if (done_ok_s) begin
                        o_wr_en         = 1'b1;
                        o_block_replace = 1'b1;
                    end else if (done_err_s) begin
                        o_bus_error = 1'b1;
                    end else begin
                        o_wr_en = 1'b0;
                    end
                end
                default: o_stall = 1'b0;
            endcase
        end
    end

endmodule
